div_rem_nb: RTL and testbench

Multi-cycle N-bit integer divider for the RV32M DIV/DIVU/REM/REMU instructions. Sits beside the single-cycle ALU compare and arithmetic units in the execute stage. It uses a restoring shift/compare/subtract loop: one quotient bit per cycle, with a fixed latency. It reuses the same signed/unsigned operand conventions as the ALU comparators. The execute stage stalls on `busy_o` and captures `r_o` when `valid_o` pulses.

---
 rtl/div_rem_nb_pkg.sv | 8 +
 rtl/div_iter_step.sv | 15 +
 rtl/div_rem_nb.sv | 72 +++++++
 tb/tb_div_rem_nb.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/div_rem_nb_pkg.sv
// div_rem_nb_pkg: shared ALU encodings for the divider (ops, FSM states, counter width).
package div_rem_nb_pkg;
  typedef enum logic [1:0] {OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/div_iter_step.sv
// div_iter_step: one restoring step; shift in the next dividend bit, subtract divisor if it fits.
module div_iter_step #(
  parameter int N = 32
) (
  input  logic [N-1:0] rem,
  input  logic         msb,
  input  logic [N-1:0] dvs,
  output logic [N-1:0] rem_next,
  output logic         q_bit
);
  logic [N:0] shifted;
  assign shifted = {rem, msb};
  assign q_bit = shifted >= {1'b0, dvs};
  assign rem_next = q_bit ? N'(shifted - {1'b0, dvs}) : shifted[N-1:0];
endmodule

// File: rtl/div_rem_nb.sv
// div_rem_nb: fixed-latency restoring divider for DIV/DIVU/REM/REMU.
module div_rem_nb
  import div_rem_nb_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         valid_o,
  output logic [N-1:0] r_o
);
  localparam int CW = cnt_width(N);
  div_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [N-1:0] rem, dvd, dvs, rem_nx, q_fix, r_fix;
  logic q_bit, neg_q, neg_r, is_rem, a_neg, b_neg, accept;
  assign a_neg = ~op_i[0] & a_i[N-1];
  assign b_neg = ~op_i[0] & b_i[N-1];
  assign accept = start_i && (state == IDLE || state == DONE);
  assign busy_o = state == CALC || state == FIX;
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;
  div_iter_step #(.N(N)) u_step (
    .rem(rem),
    .msb(dvd[N-1]),
    .dvs(dvs),
    .rem_next(rem_nx),
    .q_bit(q_bit)
  );
  always_comb begin
    state_n = state;
    if (state == IDLE || state == DONE) state_n = start_i ? CALC : IDLE;
    else if (state == CALC) state_n = cnt == '0 ? FIX : CALC;
    else state_n = DONE;
  end
  always_ff @(posedge clk_i) state <= rst_i ? IDLE : state_n;
  // b=0 keeps neg_q clear so signed DIV by zero yields all ones, not its negation
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      is_rem <= 1'b0;
      valid_o <= 1'b0;
      r_o <= '0;
    end else begin
      valid_o <= state == FIX;
      if (accept) begin
        cnt <= CW'(N - 1);
        rem <= '0;
        dvd <= a_neg ? -a_i : a_i;
        dvs <= b_neg ? -b_i : b_i;
        neg_q <= (a_neg ^ b_neg) && b_i != '0;
        neg_r <= a_neg;
        is_rem <= op_i[1];
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        rem <= rem_nx;
        dvd <= {dvd[N-2:0], q_bit};
      end
      if (state == FIX) r_o <= is_rem ? r_fix : q_fix;
    end
  end
endmodule

// File: tb/tb_div_rem_nb.sv
// tb_div_rem_nb: randomized and directed checks of div_rem_nb against an arithmetic model.
module tb_div_rem_nb;
  logic clk = 0, rst_i = 1, start_i = 0;
  logic [1:0] op_i = 0;
  logic [31:0] a_i = 0, b_i = 0, r_o;
  logic busy_o, valid_o;
  int total = 0, bad = 0, cyc = 0, acc_c = -1000;
  logic rst_d = 0;
  logic [31:0] hold = 0;
  typedef struct {int at; logic [31:0] r;} exp_t;
  exp_t q[$];

  div_rem_nb #(.N(32)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .busy_o(busy_o), .valid_o(valid_o), .r_o(r_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_d <= rst_i;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    if (b == 0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'h0 : a;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? a % b : a / b;
  endfunction

  // Cycle-by-cycle compare against the expected busy window and result queue
  always @(negedge clk) begin
    if (cyc >= 1) begin
      logic ev;
      logic [31:0] er;
      ev = 0;
      er = 0;
      if (rst_d) hold = 0;
      if (q.size() > 0 && q[0].at == cyc) begin
        ev = 1;
        er = q[0].r;
        void'(q.pop_front());
        hold = er;
      end
      chk("valid", {31'b0, valid_o}, {31'b0, ev});
      chk("busy", {31'b0, busy_o}, {31'b0, (cyc >= acc_c + 1 && cyc <= acc_c + 33)});
      chk("r_hold", r_o, hold);
    end
  end

  task automatic go(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_i = op;
    a_i = a;
    b_i = b;
    start_i = 1;
    if (!(cyc >= acc_c + 1 && cyc <= acc_c + 33)) begin
      acc_c = cyc;
      q.push_back('{cyc + 34, model(op, a, b)});
    end
    @(negedge clk);
    start_i = 0;
  endtask

  task automatic wait_valid(input string name, input int s, input logic [31:0] exp);
    while (!valid_o && cyc - s < 40) @(negedge clk);
    chk({name, "_lat"}, 32'(cyc - s), 32'd34);
    chk(name, r_o, exp);
    chk({name, "_busy"}, {31'b0, busy_o}, 32'd0);
  endtask

  task automatic run(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    int s;
    s = cyc;
    go(op, a, b);
    wait_valid(name, s, exp);
  endtask

  task automatic do_reset(input logic with_start);
    rst_i = 1;
    start_i = with_start;
    @(posedge clk);
    #1;
    acc_c = -1000;
    q.delete();
    @(negedge clk);
    rst_i = 0;
    start_i = 0;
  endtask

  initial begin
    int s;
    logic [1:0] op;
    logic [31:0] a, b;
    chk("model_divu", model(2'b01, 100, 7), 32'd14);
    chk("model_div", model(2'b00, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFD);
    chk("model_rem", model(2'b10, 32'hFFFF_FFF9, 2), 32'hFFFF_FFFF);
    chk("model_ovf", model(2'b00, 32'h8000_0000, 32'hFFFF_FFFF), 32'h8000_0000);
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, busy_o}, 0);
    chk("rst_valid", {31'b0, valid_o}, 0);
    chk("rst_r", r_o, 0);
    rst_i = 0;
    @(negedge clk);
    run("divu", 2'b01, 100, 7, 14);
    repeat (2) @(negedge clk);
    run("remu", 2'b11, 100, 7, 2);
    run("div_neg", 2'b00, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
    run("rem_neg", 2'b10, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
    run("rem_negb", 2'b10, 7, 32'hFFFF_FFFE, 1);
    run("divu_z", 2'b01, 5, 0, 32'hFFFF_FFFF);
    run("div_z", 2'b00, 5, 0, 32'hFFFF_FFFF);
    run("div_zn", 2'b00, 32'hFFFF_FFFB, 0, 32'hFFFF_FFFF);
    run("remu_z", 2'b11, 5, 0, 5);
    run("rem_z", 2'b10, 5, 0, 5);
    run("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 1);
    run("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
    @(negedge clk);
    s = cyc;
    go(2'b01, 100, 7);
    repeat (4) @(negedge clk);
    go(2'b11, 999, 10);
    wait_valid("bp_first", s, 14);
    run("bp_done_start", 2'b10, 32'hFFFF_FF9C, 7, 32'hFFFF_FFFE);
    @(negedge clk);
    go(2'b01, 1000, 3);
    repeat (8) @(negedge clk);
    do_reset(0);
    chk("abort_busy", {31'b0, busy_o}, 0);
    chk("abort_valid", {31'b0, valid_o}, 0);
    chk("abort_r", r_o, 0);
    repeat (40) @(negedge clk);
    do_reset(1);
    chk("rst_start_busy", {31'b0, busy_o}, 0);
    repeat (3) @(negedge clk);
    for (int i = 0; i < 150; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 20);
        3: a = 32'h8000_0000;
        4: b = -$urandom_range(1, 20);
        default: ;
      endcase
      s = cyc;
      go(op, a, b);
      while (!valid_o && cyc - s < 40) @(negedge clk);
      chk("rand_lat", 32'(cyc - s), 32'd34);
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    repeat (40) @(negedge clk);
    chk("queue_empty", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
